// File: rtl/rtc_timekeeper.sv
// Time-of-day core: prescaled seconds/minutes/hours chain, debounced mode/add keys,
// and a registered four-digit BCD display with blanking for 12h format and field editing.
module rtc_timekeeper #(
  parameter int TICKS_PER_SEC = 65536,
  parameter int DEBOUNCE_LEN  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_mode,
  input  logic        key_add,
  input  logic        fmt_12h,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic [15:0] disp_bcd,
  output logic [3:0]  digit_blank,
  output logic        pm,
  output logic [2:0]  mode,
  output logic        sec_pulse
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LEN - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    RUN_HM     = 3'd0,
    RUN_MS     = 3'd1,
    SET_HOUR   = 3'd2,
    SET_MINUTE = 3'd3,
    STOP       = 3'd4
  } mode_t;

  mode_t         state;
  logic [1:0]    raw_keys;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];
  logic [PW-1:0] presc;
  logic [PW-1:0] blink_cnt;
  logic          blink_phase;
  logic          running;
  logic          tick;
  logic          add_hour;
  logic          add_min;
  logic [4:0]    disp_hour;
  logic [7:0]    hh_bcd;
  logic [7:0]    mm_bcd;
  logic [7:0]    ss_bcd;
  logic          show_ms;
  logic [15:0]   disp_next;
  logic [3:0]    blank_next;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  assign raw_keys = {key_add, key_mode};

  // Key path: two-flop synchroniser, then a counter that must see DEBOUNCE_LEN
  // consecutive disagreeing samples before the debounced level follows.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      press <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= raw_keys;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] != db[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            db[k]     <= sync2[k];
            db_cnt[k] <= '0;
            press[k]  <= sync2[k];
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN_HM;
    end else begin
      case (state)
        RUN_HM:     if (press[0]) state <= RUN_MS;
        RUN_MS:     if (press[0]) state <= SET_HOUR;
        SET_HOUR:   if (press[0]) state <= SET_MINUTE;
        SET_MINUTE: if (press[0]) state <= STOP;
        STOP:       if (press[0]) state <= RUN_HM;
        default:    state <= RUN_HM;
      endcase
    end
  end

  assign mode        = state;
  assign running     = (state == RUN_HM) || (state == RUN_MS);
  assign tick        = running && (presc == PS_LAST);
  assign blink_phase = ~blink_cnt[PW-1];
  // A mode press in the same cycle wins; the add is dropped.
  assign add_hour    = (state == SET_HOUR)   && press[1] && !press[0];
  assign add_min     = (state == SET_MINUTE) && press[1] && !press[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (!running || tick) presc <= '0;
      else                  presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick;
      if (tick) begin
        if (second == 6'd59) begin
          second <= '0;
          if (minute == 6'd59) begin
            minute <= '0;
            hour   <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end else begin
            minute <= minute + 6'd1;
          end
        end else begin
          second <= second + 6'd1;
        end
      end else if (add_hour) begin
        hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end else if (add_min) begin
        minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        second <= '0;
      end
    end
  end

  always_comb begin
    disp_hour = hour;
    if (fmt_12h) begin
      if (hour == 5'd0)      disp_hour = 5'd12;
      else if (hour > 5'd12) disp_hour = hour - 5'd12;
    end
    hh_bcd  = to_bcd({1'b0, disp_hour});
    mm_bcd  = to_bcd(minute);
    ss_bcd  = to_bcd(second);
    show_ms = (state == RUN_MS);
    disp_next  = show_ms ? {mm_bcd, ss_bcd} : {hh_bcd, mm_bcd};
    blank_next = 4'b0000;
    if (!show_ms && fmt_12h && (disp_hour < 5'd10)) blank_next[3] = 1'b1;
    if ((state == SET_HOUR) && !blink_phase)   blank_next[3:2] = 2'b11;
    if ((state == SET_MINUTE) && !blink_phase) blank_next[1:0] = 2'b11;
  end

  // Display stage: one cycle behind the binary fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_bcd    <= '0;
      digit_blank <= '0;
      pm          <= 1'b0;
    end else begin
      disp_bcd    <= disp_next;
      digit_blank <= blank_next;
      pm          <= (hour >= 5'd12);
    end
  end

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised time-of-day core for the 7-segment clock: a programmable prescaler drives a seconds/minutes/hours counter chain, and two debounced push-buttons select the display mode and set the time. It replaces the fixed 16-bit-prescaler clock logic in the top level. It sits between the raw key pins and the segment multiplexer, which it feeds four registered BCD digits plus a per-digit blank mask. New behaviour over the previous generation:
- parametrised tick rate and debounce length
- 12/24-hour display
- MM:SS view
- blinking of the field being edited

## Interface
- TICKS_PER_SEC, 65536: clock cycles per second, ≥ 4; prescaler width is clog2(TICKS_PER_SEC).
- DEBOUNCE_LEN, 1024: consecutive stable cycles required to accept a key change, ≥ 1.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_mode  in  1  raw mode button, active high, asynchronous to clock.
- key_add  in  1  raw increment button, active high, asynchronous to clock.
- fmt_12h  in  1  1 = 12-hour display, 0 = 24-hour display; sampled every cycle.
- hour  out  5  binary hour, 0–23, always 24-hour.
- minute  out  6  binary minute, 0–59.
- second  out  6  binary second, 0–59.
- disp_bcd  out  16  four BCD digits {d3,d2,d1,d0}, registered.
- digit_blank  out  4  1 = blank that digit; bit i corresponds to d_i.
- pm  out  1  1 when hour ≥ 12, in either format.
- mode  out  3  current mode-FSM state.
- sec_pulse  out  1  one-cycle pulse on every second increment.

## Operation
- **Key path**
  - Each key passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised value has differed from it for DEBOUNCE_LEN consecutive cycles.
  - A press event is a one-cycle pulse on the debounced rising edge. Releases generate no event.
- **Mode FSM**
  - States: RUN_HM=0, RUN_MS=1, SET_HOUR=2, SET_MINUTE=3, STOP=4.
  - A key_mode press advances the state 0→1→2→3→4→0. Encodings 5–7 return to RUN_HM on the next cycle.
- **Timekeeping**
  - The prescaler counts 0..TICKS_PER_SEC-1 only in RUN_HM and RUN_MS. In the other states it is held at 0.
  - A tick fires when the prescaler wraps. At a tick:
    - second increments;
    - 59→0 carries into minute;
    - minute 59→0 carries into hour;
    - hour 23→0.
  - Carries are combinational within the tick cycle, so 23:59:59 becomes 00:00:00 in a single cycle.
- **Setting the time**
  - In SET_HOUR, a key_add press sets hour to (hour+1) mod 24.
  - In SET_MINUTE, a key_add press sets minute to (minute+1) mod 60 and clears second to 0. There is no carry into hour.
  - key_add presses in RUN_HM, RUN_MS and STOP are ignored.
- **Display**
  - RUN_HM, SET_HOUR, SET_MINUTE and STOP show HH:MM. RUN_MS shows MM:SS.
  - The displayed hour is the 24-hour value, or in 12-hour format: 0→12, 13..23→1..11, 1..12 unchanged.
  - d3 is blanked when the displayed hour is below 10 and fmt_12h=1.
- **Blink**
  - A free-running blink counter of the same width as the prescaler (never held) drives blink_phase. blink_phase=1 during the first half of its period.
  - In SET_HOUR, d3 and d2 are blanked while blink_phase=0. In SET_MINUTE, d1 and d0 are blanked while blink_phase=0.
- **Simultaneous events**
  - A key_mode press and a key_add press in the same cycle: the mode change applies and the add is dropped.
  - A tick cannot coincide with an add press, because no tick occurs in the set states.

## Timing
- Reset values: hour=0, minute=0, second=0, mode=0, disp_bcd=16'h0000, digit_blank=4'b0000, pm=0, sec_pulse=0. The prescaler, blink counter, synchronisers and debouncers all reset to 0.
- Reset asserted mid-operation clears everything immediately, including any debounce in progress.
- Key latency: press event at 2 + DEBOUNCE_LEN cycles after a clean raw rising edge. The state or field update follows 1 cycle later.
- hour, minute and second update on the clock edge where the tick or add is seen. sec_pulse is high in that same cycle.
- disp_bcd, digit_blank and pm lag the binary fields by 1 cycle.
- Leaving a set state resets nothing. The first tick after re-entering RUN_HM comes exactly TICKS_PER_SEC cycles later.

## Test plan
- Use TICKS_PER_SEC=8 and DEBOUNCE_LEN=4 throughout.
- **Rollover:** preset 23:59:59 via the set modes, then run 8 cycles in RUN_HM → 00:00:00 and sec_pulse high for exactly 1 cycle. With fmt_12h=1 → disp_bcd=16'h1200 and pm=0.
- **Bounce rejection:** key_mode toggling every 2 cycles for 20 cycles, then held high → exactly one mode advance, at 6 cycles after the hold begins.
- **Mode wrap and set:** 2 presses to SET_HOUR, then 25 key_add presses → hour=1. Then 1 press to SET_MINUTE and 61 key_add presses → minute=1, second=0. Prescaler stays 0 throughout.
- **Blink:** in SET_MINUTE, observe over 8 cycles → digit_blank=4'b0011 for 4 cycles and 4'b0000 for 4 cycles. In RUN_MS → disp_bcd shows MMSS and never blinks.
- **12h display:** hour=13, minute=5, fmt_12h=1 → disp_bcd=16'h0105, digit_blank[3]=1, pm=1. fmt_12h=0 → 16'h1305, digit_blank=0.
- **Async reset:** assert reset mid-debounce and mid-count at 10:20:30 → all outputs reach their reset values without a clock edge. No press event is generated after release.
